// File: rtl/lcd_mem_pkg.sv
// Shared types and constants for the LCD convolution memory front end.
// Holds the loader state encoding, RAM enable encodings and default RAM depths.
package lcd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_INP,
    LOAD_FIL,
    DONE
  } load_state_t;

  // {ce, we} pairs driven to the RAMs
  localparam logic [1:0] EN_OFF = 2'b00;
  localparam logic [1:0] EN_WR  = 2'b11;

  localparam int DEF_INP_DEPTH = 16;
  localparam int DEF_FIL_DEPTH = 9;

endpackage

// File: rtl/memory_loader.sv
// Streams bytes from a valid/ready source into the input-matrix RAM, then the filter RAM.
// Memory-side outputs are registered; done pulses alongside the final filter write.
module memory_loader
  import lcd_mem_pkg::*;
#(
  parameter int INP_DEPTH = DEF_INP_DEPTH,
  parameter int FIL_DEPTH = DEF_FIL_DEPTH,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    data,
  output logic [AW-1:0] addr_w,
  output logic [1:0]    en_INP,
  output logic [1:0]    en_FIL,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] INP_LAST = AW'(INP_DEPTH - 1);
  localparam logic [AW-1:0] FIL_LAST = AW'(FIL_DEPTH - 1);

  load_state_t   state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          wr_inp, wr_fil;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // in_ready/busy/done decode from state only, never from in_valid
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wr_inp   = 1'b0;
    wr_fil   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD_INP;
          cnt_nx   = '0;
        end
      end
      LOAD_INP: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          wr_inp = 1'b1;
          if (cnt == INP_LAST) begin
            state_nx = LOAD_FIL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      LOAD_FIL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          wr_fil = 1'b1;
          if (cnt == FIL_LAST) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // data/addr_w hold between accepts; enables fall back to off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= 8'h00;
      addr_w <= '0;
      en_INP <= EN_OFF;
      en_FIL <= EN_OFF;
    end else begin
      en_INP <= wr_inp ? EN_WR : EN_OFF;
      en_FIL <= wr_fil ? EN_WR : EN_OFF;
      if (wr_inp || wr_fil) begin
        data   <= in_data;
        addr_w <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: scenario table plus reset sequences,
// checked against an expected write list and a bench-side model of both RAMs.
module tb_memory_loader;
  localparam int INP = 16;
  localparam int FIL = 9;
  localparam int NB  = INP + FIL;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    data;
  logic [AW-1:0] addr_w;
  logic [1:0]    en_INP, en_FIL;
  logic          busy, done;

  memory_loader #(.INP_DEPTH(INP), .FIL_DEPTH(FIL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data(data), .addr_w(addr_w), .en_INP(en_INP),
    .en_FIL(en_FIL), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int fil; int addr; int dat; } wr_t;
  typedef struct { int mode; int pat; int spur; int lat_min; int lat_max; } vec_t;

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, mon_bad = 0, rdy_bad = 0;
  wr_t obs[$];
  logic [7:0] bytes [NB];
  logic [7:0] inp_mem [16];
  logic [7:0] fil_mem [16];

  always @(posedge clk) cyc++;

  // Model of the two RAMs: capture on the edge after the loader drives a write
  always @(posedge clk) begin
    if (en_INP == 2'b11) inp_mem[addr_w] <= data;
    if (en_FIL == 2'b11) fil_mem[addr_w] <= data;
  end

  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (en_INP == 2'b11) begin w = '{0, int'(addr_w), int'(data)}; obs.push_back(w); end
      if (en_FIL == 2'b11) begin w = '{1, int'(addr_w), int'(data)}; obs.push_back(w); end
      if (en_INP != 2'b00 && en_FIL != 2'b00) mon_bad++;
      if ((en_INP != 2'b00 && en_INP != 2'b11) || (en_FIL != 2'b00 && en_FIL != 2'b11)) mon_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!(en_FIL == 2'b11 && int'(addr_w) == FIL - 1)) mon_bad++;
        if (in_ready || busy) mon_bad++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic pick(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return (c % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clear_stats();
    obs.delete();
    done_cnt = 0;
    mon_bad  = 0;
    rdy_bad  = 0;
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < NB; i++)
      bytes[i] = (pat == 0) ? 8'(i + 1) : 8'($urandom);
    if (pat == 2) begin
      bytes[INP-1] = 8'hAA;
      bytes[INP]   = 8'hBB;
    end
  endtask

  // Pulse start, then offer n bytes; the source holds a byte until it is taken
  task automatic feed(input int n, input int mode, input int spur, input int maxcyc);
    int idx = 0;
    int c = 0;
    logic rdy_drv;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    while (idx < n && c < maxcyc) begin
      in_valid = pick(mode, c);
      in_data  = in_valid ? bytes[idx] : 8'($urandom);
      start    = (spur >= 0 && idx == spur);
      rdy_drv  = in_ready;
      if (!in_ready || !busy) rdy_bad++;
      @(negedge clk);
      c++;
      if (in_valid && rdy_drv) idx++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("feed_complete", idx, n);
  endtask

  task automatic check_load(input int lat_min, input int lat_max);
    int mism = 0;
    int lat;
    repeat (3) @(negedge clk);
    chk("write_count", obs.size(), NB);
    for (int i = 0; i < NB && i < obs.size(); i++) begin
      if (i < INP) begin
        if (obs[i].fil != 0 || obs[i].addr != i || obs[i].dat != int'(bytes[i])) mism++;
      end else begin
        if (obs[i].fil != 1 || obs[i].addr != i - INP || obs[i].dat != int'(bytes[i])) mism++;
      end
    end
    chk("write_order", mism, 0);
    chk("done_pulses", done_cnt, 1);
    chk("monitor_rules", mon_bad, 0);
    chk("ready_during_load", rdy_bad, 0);
    lat = done_cyc - start_cyc;
    chk("done_latency_in_range", int'(lat >= lat_min && lat <= lat_max), 1);
    mism = 0;
    for (int i = 0; i < INP; i++) if (inp_mem[i] !== bytes[i]) mism++;
    for (int i = 0; i < FIL; i++) if (fil_mem[i] !== bytes[INP+i]) mism++;
    chk("ram_contents", mism, 0);
    chk("inp_ram_addr5", int'(inp_mem[5]), int'(bytes[5]));
    chk("fil_ram_addr8", int'(fil_mem[8]), int'(bytes[NB-1]));
  endtask

  function automatic int outs_packed();
    return int'({in_ready, data, addr_w, en_INP, en_FIL, busy, done});
  endfunction

  vec_t tbl[5];

  initial begin
    int rdy_seen;
    // mode: 0 steady valid, 1 alternate cycles, 2 random; pat: 0 incrementing, 1 random, 2 AA/BB boundary
    tbl[0] = '{0, 0, -1, NB, NB};
    tbl[1] = '{1, 0, -1, 2*NB-2, 2*NB+1};
    tbl[2] = '{0, 2, -1, NB, NB};
    tbl[3] = '{0, 1, INP+4, NB, NB};
    tbl[4] = '{2, 1, -1, NB, 400};

    #1;
    chk("reset_outputs_zero", outs_packed(), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready || busy) rdy_seen++;
    end
    in_valid = 1'b0;
    chk("idle_no_ready", rdy_seen, 0);
    chk("idle_no_writes", obs.size(), 0);

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].pat);
      clear_stats();
      feed(NB, tbl[t].mode, tbl[t].spur, 400);
      check_load(tbl[t].lat_min, tbl[t].lat_max);
      if (tbl[t].pat == 2 && obs.size() > INP) begin
        chk("boundary_last_inp_addr", obs[INP-1].addr, INP - 1);
        chk("boundary_last_inp_data", obs[INP-1].dat, 'hAA);
        chk("boundary_first_fil_sel", obs[INP].fil, 1);
        chk("boundary_first_fil_addr", obs[INP].addr, 0);
        chk("boundary_first_fil_data", obs[INP].dat, 'hBB);
      end
    end

    // Reset partway through the input matrix, then a clean reload
    fill(1);
    clear_stats();
    feed(7, 0, -1, 100);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_outputs_zero", outs_packed(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", int'(in_ready), 0);
    fill(1);
    clear_stats();
    feed(NB, 0, -1, 400);
    check_load(NB, NB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_loader.md
# memory_loader

Front-end writer for the main memory module: accepts a byte stream over a valid/ready handshake and writes it into the input-matrix RAM (16 bytes, 4×4) and then the filter RAM (9 bytes, 3×3), generating the shared write-data bus, write address and `{ce, we}` enable pairs. It sits between the host/UART byte source and the memory module, and pulses `done` once both RAMs are loaded so the convolution controller can start.

## Interface
Parameters:
- `INP_DEPTH`, 16, number of input-matrix bytes written (addresses 0..INP_DEPTH-1)
- `FIL_DEPTH`, 9, number of filter bytes written (addresses 0..FIL_DEPTH-1)
- `AW`, 4, write-address width; INP_DEPTH and FIL_DEPTH must each be ≤ 2^AW

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a load sequence; sampled only in IDLE
- `in_data`  in  8  incoming byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader can accept a byte this cycle
- `data`  out  8  write-data bus to memory
- `addr_w`  out  AW  write address, driven to both `addr_A0` and `addr_F0`
- `en_INP`  out  2  `{ce, we}` for the input-matrix RAM
- `en_FIL`  out  2  `{ce, we}` for the filter RAM
- `busy`  out  1  high in LOAD_INP and LOAD_FIL
- `done`  out  1  one-cycle pulse after the last filter byte is written

## Operation
- States: IDLE, LOAD_INP, LOAD_FIL, DONE. One counter `cnt` (AW bits).
- IDLE: `in_ready`=0. `start`=1 → LOAD_INP, `cnt`←0.
- LOAD_INP: `in_ready`=1. On accept (`in_valid & in_ready`): register `data`←`in_data`, `addr_w`←`cnt`, `en_INP`←2'b11. If `cnt`==INP_DEPTH-1 → LOAD_FIL, `cnt`←0; else `cnt`←`cnt`+1.
- LOAD_FIL: same as LOAD_INP, but drives `en_FIL`←2'b11. If `cnt`==FIL_DEPTH-1 → DONE.
- DONE: `in_ready`=0, `done`=1 for exactly one cycle, then → IDLE.
- Cycles without an accept: `en_INP`=`en_FIL`=2'b00; `data` and `addr_w` hold their last values.
- `en_INP` and `en_FIL` are never non-zero in the same cycle.
- `start` outside IDLE is ignored. A `start` asserted in the DONE cycle is ignored (IDLE samples it on the following cycle).
- Bytes offered while `in_ready`=0 are not consumed; the source must hold them.
- Reset mid-sequence: return to IDLE and zero all outputs. Memory contents already written are left as they are; a new `start` reloads from address 0.

## Timing
- Reset values: `in_ready`=0, `data`=8'h00, `addr_w`=0, `en_INP`=2'b00, `en_FIL`=2'b00, `busy`=0, `done`=0, state=IDLE, `cnt`=0.
- `in_ready` and `busy` decode from state only; they do not depend combinationally on `in_valid`.
- All memory-side outputs are registered. A byte accepted at edge N appears on `data`/`addr_w`/`en_*` after edge N. The RAM captures it at edge N+1.
- Full throughput: one byte per cycle while `in_valid` stays high. Minimum sequence from `start` to `done` is 1 + INP_DEPTH + FIL_DEPTH + 1 cycles (27 with defaults).
- The last filter write (`en_FIL`=2'b11) and `done`=1 are driven in the same cycle. `done` is therefore visible to consumers one edge before the final byte is committed in the RAM, and they must wait one cycle after sampling `done` before reading filter address FIL_DEPTH-1.
- `in_valid` gaps stretch the sequence. They produce no spurious writes and leave `cnt` unchanged.

## Structure
- Shared package `lcd_mem_pkg`:
  - state enum `load_state_t` (IDLE, LOAD_INP, LOAD_FIL, DONE)
  - enable encodings `EN_OFF`=2'b00 and `EN_WR`=2'b11
  - default depths 16 and 9
- Single flat module, no sub-modules; the counter and FSM are small enough to inline.

## Test plan
- Reset then idle: hold `rst`=1 mid-cycle (async) → all outputs 0 immediately. Release `rst`, `in_valid`=1, no `start` → `in_ready`=0 and no writes for 20 cycles.
- Back-to-back load: `start`, then bytes 0x01..0x19 with `in_valid` held high → 16 `en_INP`=11 writes (address 0..15, data 0x01..0x10), then 9 `en_FIL`=11 writes (address 0..8, data 0x11..0x19). `done` pulses in the same cycle as the address-8 filter write. Read back through memory ports: `out_A0`@addr 5=0x06, `out_F0`@addr 8=0x19.
- Bubbles: toggle `in_valid` every other cycle → same 25 writes in the same order, 0 extra writes, `done` roughly 2× later.
- Boundary: the 16th byte (0xAA) goes to INP address 15. The next byte (0xBB) produces `en_FIL`=11 at address 0 and never touches the INP RAM.
- Reset mid-operation: assert `rst` after 7 input bytes → IDLE, outputs 0. A new `start` with 25 bytes writes from INP address 0 again.
- Spurious start: pulse `start` during LOAD_FIL → no effect; sequence and `done` timing match the back-to-back case.
